// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit: EX and ID operand forwards, load-use and branch stalls, freeze, watchdog.
// Latency: forwards, stalls and hazard_code are combinational; FSM, watchdog and counters update at the clock edge.
// Backpressure: mem_busy freezes the whole pipe (stall without a bubble); hazards stall IF/ID and flush ID/EX.
// Optional macro HAZARD_PERF_CNT_EN: enables stall/flush/forward performance counters (tied to 0 otherwise).
module hazard_forward_unit #(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             branch_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       writereg_e,
  input  logic             regwrite_e,
  input  logic             memtoreg_e,
  input  logic [4:0]       writereg_m,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_w,
  input  logic             mem_busy,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             freeze,
  output logic [1:0]       hazard_code,
  output logic             hazard_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] fwd_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

  state_t     state_q, state_d;
  logic [7:0] run_len_q, run_len_d;
  logic       hazard_error_q, hazard_error_d;

  logic       mem_hit_rs_e, mem_hit_rt_e, wb_hit_rs_e, wb_hit_rt_e;
  logic       ex_hit_d, mem_load_hit_d;
  logic       lwstall, brstall, hazard_stall, fwd_any;

  // Forward selects: register 0 never matches, MEM result is newer than WB so it wins.
  always_comb begin
    mem_hit_rs_e = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rs_e);
    mem_hit_rt_e = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rt_e);
    wb_hit_rs_e  = regwrite_w && (writereg_w != 5'd0) && (writereg_w == rs_e);
    wb_hit_rt_e  = regwrite_w && (writereg_w != 5'd0) && (writereg_w == rt_e);

    forward_a_e = 2'b00;
    if (mem_hit_rs_e)     forward_a_e = 2'b10;
    else if (wb_hit_rs_e) forward_a_e = 2'b01;

    forward_b_e = 2'b00;
    if (mem_hit_rt_e)     forward_b_e = 2'b10;
    else if (wb_hit_rt_e) forward_b_e = 2'b01;

    forward_a_d = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rs_d);
    forward_b_d = regwrite_m && (writereg_m != 5'd0) && (writereg_m == rt_d);

    fwd_any = (forward_a_e != 2'b00) || (forward_b_e != 2'b00);
  end

  // Stall, flush and freeze decisions plus the prioritised hazard code.
  always_comb begin
    lwstall = memtoreg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

    // A branch compared in ID cannot see an EX result or a load still in MEM.
    ex_hit_d       = regwrite_e && (writereg_e != 5'd0) &&
                     ((writereg_e == rs_d) || (writereg_e == rt_d));
    mem_load_hit_d = memtoreg_m && (writereg_m != 5'd0) &&
                     ((writereg_m == rs_d) || (writereg_m == rt_d));
    brstall        = branch_d && (ex_hit_d || mem_load_hit_d);

    hazard_stall = lwstall || brstall;
    stall_f      = hazard_stall || mem_busy;
    stall_d      = stall_f;
    // A freeze holds every stage, so inserting a bubble would drop an instruction.
    flush_e      = hazard_stall && !mem_busy;
    freeze       = mem_busy;

    if (brstall)      hazard_code = 2'b11;
    else if (lwstall) hazard_code = 2'b10;
    else if (fwd_any) hazard_code = 2'b01;
    else              hazard_code = 2'b00;
  end

  // Stall-episode FSM: a freeze takes precedence over a hazard stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy)          state_d = ST_FREEZE;
        else if (hazard_stall) state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      ST_STALL: begin
        if (mem_busy)          state_d = ST_FREEZE;
        else if (hazard_stall) state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      ST_FREEZE: begin
        if (mem_busy)          state_d = ST_FREEZE;
        else if (hazard_stall) state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      default:                 state_d = ST_RUN;
    endcase
  end

  // Watchdog: saturating run length of stalled cycles; error is sticky once the limit is hit.
  always_comb begin
    if (!stall_f)                run_len_d = 8'd0;
    else if (run_len_q == 8'hFF) run_len_d = 8'hFF;
    else                         run_len_d = run_len_q + 8'd1;

    hazard_error_d = hazard_error_q || (stall_f && (run_len_d == MAX_STALL_L));
  end

  // State, run length and error flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      run_len_q      <= 8'd0;
      hazard_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_len_q      <= run_len_d;
      hazard_error_q <= hazard_error_d;
    end
  end

  assign hazard_error = hazard_error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Free-running event counters; they wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_e);
    fwd_cnt_d   = fwd_cnt_q + CNT_W'(fwd_any);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
  assign fwd_count   = '0;
`endif

endmodule
